// File: rtl/gps_uart_rx.sv
// 8N1 asynchronous receiver for the GPS serial line: two-flop synchroniser,
// mid-bit sampling, start-glitch rejection and framing-error reporting.
module gps_uart_rx #(
    parameter int B            = 8,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic [B-1:0] data,
    output logic         load,
    output logic         frame_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] H_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] I_LAST = IW'(B - 1);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [1:0]    fill;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [B-1:0]  shreg, shreg_n, data_n;
    logic          load_n, ferr_n;

    // The synchroniser's reset value says nothing about the line; fill marks
    // when rx_s carries real samples so WAIT_HIGH only trusts a true idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            fill <= 2'b00;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            fill <= {fill[0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_HIGH;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data        <= '0;
            load        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            data        <= data_n;
            load        <= load_n;
            frame_error <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data;
        load_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            WAIT_HIGH: begin
                cnt_n = '0;
                if (fill[1] && rx_s) state_n = IDLE;
            end
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == H_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == C_LAST) begin
                    cnt_n        = '0;
                    shreg_n[idx] = rx_s;
                    if (idx == I_LAST) state_n = STOP;
                    else               idx_n   = idx + IW'(1);
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a start edge right after it be caught.
                if (cnt == C_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        load_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            default: state_n = WAIT_HIGH;
        endcase
    end

endmodule

// File: tb/tb_gps_uart_rx.sv
// Directed bench for gps_uart_rx at 16 clocks per bit.
module tb_gps_uart_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       load, frame_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q[$];
    int         n_load = 0, n_fe = 0, n_both = 0, load_cyc = 0;

    gps_uart_rx #(.B(8), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .data(data), .load(load), .frame_error(frame_error)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (load) begin
            q.push_back(data);
            n_load++;
            load_cyc = cyc;
        end
        if (frame_error) n_fe++;
        if (load && frame_error) n_both++;
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        #5;
        total++;
        if (data !== 8'h00 || load !== 1'b0 || frame_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got data=%h load=%b fe=%b want 00/0/0", data, load, frame_error);
        end
        repeat (3) @(negedge clock);
        total++;
        if (data !== 8'h00 || load !== 1'b0 || frame_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_held got data=%h load=%b fe=%b want 00/0/0", data, load, frame_error);
        end
        reset = 1'b1;
        idle(10);
    endtask

    task automatic test_single;
        int l0, f0, start;
        l0 = n_load; f0 = n_fe; start = cyc;
        send_byte(8'h24, 1'b1);
        idle(4);
        total++;
        if (n_load - l0 != 1) begin
            bad++; $display("FAIL single_count got=%0d want=1", n_load - l0);
        end
        total++;
        if (load_cyc - start != 155) begin
            bad++; $display("FAIL single_latency got=%0d want=155", load_cyc - start);
        end
        total++;
        if (data !== 8'h24) begin
            bad++; $display("FAIL single_data got=%h want=24", data);
        end
        total++;
        if (n_fe != f0) begin
            bad++; $display("FAIL single_fe got=%0d want=0", n_fe - f0);
        end
    endtask

    task automatic test_back_to_back;
        string s;
        int l0, f0, q0;
        logic [7:0] want;
        s  = "$GPZDA,143042.00,25,08,2005,,*6E\r\n";
        l0 = n_load; f0 = n_fe; q0 = q.size();
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        idle(20);
        total++;
        if (n_load - l0 != 34) begin
            bad++; $display("FAIL sentence_count got=%0d want=34", n_load - l0);
        end
        for (int i = 0; i < s.len(); i++) begin
            want = s[i];
            total++;
            if (q.size() <= q0 + i) begin
                bad++; $display("FAIL sentence_byte%0d missing want=%h", i, want);
            end else if (q[q0 + i] !== want) begin
                bad++; $display("FAIL sentence_byte%0d got=%h want=%h", i, q[q0 + i], want);
            end
        end
        total++;
        if (q.size() < 2 || q[q.size() - 2] !== 8'h0D || q[q.size() - 1] !== 8'h0A) begin
            bad++; $display("FAIL sentence_tail size=%0d want last two 0D 0A", q.size());
        end
        total++;
        if (n_fe != f0) begin
            bad++; $display("FAIL sentence_fe got=%0d want=0", n_fe - f0);
        end
    endtask

    task automatic test_glitch;
        int l0, f0;
        l0 = n_load; f0 = n_fe;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        idle(40);
        total++;
        if (n_load != l0 || n_fe != f0) begin
            bad++; $display("FAIL glitch_quiet got load=%0d fe=%0d want 0/0", n_load - l0, n_fe - f0);
        end
        send_byte(8'h47, 1'b1);
        idle(20);
        total++;
        if (n_load - l0 != 1 || data !== 8'h47) begin
            bad++; $display("FAIL glitch_next got loads=%0d data=%h want 1/47", n_load - l0, data);
        end
    endtask

    task automatic test_frame_error;
        int l0, f0;
        l0 = n_load; f0 = n_fe;
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clock);
        idle(40);
        total++;
        if (n_fe - f0 != 1) begin
            bad++; $display("FAIL ferr_count got=%0d want=1", n_fe - f0);
        end
        total++;
        if (n_load != l0 || data !== 8'h47) begin
            bad++; $display("FAIL ferr_noload got loads=%0d data=%h want 0/47", n_load - l0, data);
        end
        send_byte(8'h0A, 1'b1);
        idle(20);
        total++;
        if (n_load - l0 != 1 || data !== 8'h0A || n_fe - f0 != 1) begin
            bad++; $display("FAIL ferr_recover got loads=%0d data=%h fe=%0d want 1/0a/1", n_load - l0, data, n_fe - f0);
        end
    endtask

    task automatic test_reset_mid;
        int l0, f0;
        logic [7:0] b;
        b = 8'hA5;
        l0 = n_load; f0 = n_fe;
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(b[i]);
        rx = b[3];
        repeat (5) @(negedge clock);
        #3 reset = 1'b0;
        #1;
        total++;
        if (data !== 8'h00 || load !== 1'b0 || frame_error !== 1'b0) begin
            bad++; $display("FAIL midreset_async got data=%h load=%b fe=%b want 00/0/0", data, load, frame_error);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (CPB - 8) @(negedge clock);
        bit_time(b[4]);
        // Sender is reset too: line returns to idle for the rest of the frame.
        idle(5 * CPB);
        total++;
        if (n_load != l0 || n_fe != f0) begin
            bad++; $display("FAIL midreset_quiet got load=%0d fe=%0d want 0/0", n_load - l0, n_fe - f0);
        end
        send_byte(8'h2A, 1'b1);
        idle(20);
        total++;
        if (n_load - l0 != 1 || data !== 8'h2A) begin
            bad++; $display("FAIL midreset_next got loads=%0d data=%h want 1/2a", n_load - l0, data);
        end
    endtask

    task automatic test_low_release;
        int l0, f0;
        l0 = n_load; f0 = n_fe;
        reset = 1'b0;
        rx    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        idle(30);
        send_byte(8'h36, 1'b1);
        idle(20);
        total++;
        if (n_load - l0 != 1 || data !== 8'h36) begin
            bad++; $display("FAIL lowrel_load got loads=%0d data=%h want 1/36", n_load - l0, data);
        end
        total++;
        if (n_fe != f0) begin
            bad++; $display("FAIL lowrel_fe got=%0d want=0", n_fe - f0);
        end
        total++;
        if (n_both != 0) begin
            bad++; $display("FAIL load_and_fe got=%0d want=0", n_both);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid;
        test_low_release;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
